// File: rtl/rc4_wctrl_pkg.sv
// ----------------------------------------------------------------------------
// rc4_wctrl_pkg
// Shared definitions for the RC4 decrypted-data write controller:
//   - wctrl_state_t : controller FSM state encoding (IDLE is all-zero)
//   - WORD_BYTES    : bytes packed per memory word
//   - LAST_LANE     : index of the final lane in a word
//   - lane_map()    : logical lane -> packer lane index
// Configuration macro: RC4_WCTRL_BIG_ENDIAN_EN
//   undefined : first byte of a word lands in packer lane 0 (LSB)
//   defined   : first byte of a word lands in packer lane 3 (MSB)
// ----------------------------------------------------------------------------
package rc4_wctrl_pkg;

    localparam int WORD_BYTES = 4;
    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COLLECT   = 3'd1,
        PACK_WAIT = 3'd2,
        WRITE     = 3'd3,
        FLUSH     = 3'd4,
        DONE      = 3'd5
    } wctrl_state_t;

    // Collection and padding both go through this mapping, so the lane
    // order of real bytes and pad bytes always agrees.
    function automatic logic [1:0] lane_map(input logic [1:0] lane);
`ifdef RC4_WCTRL_BIG_ENDIAN_EN
        return LAST_LANE - lane;
`else
        return lane;
`endif
    endfunction

endpackage

// File: rtl/rc4_core_decrypted_data.sv
// ----------------------------------------------------------------------------
// rc4_core_decrypted_data
// Byte-lane packer that sits beside the write controller. Each strobed byte
// is registered into its lane of the 32-bit word; lane 0 is the LSB.
// Ports:
//   clk, n_rst   : clock, synchronous active-low reset (clears the word)
//   enable_write : lane write strobe
//   writeLoc     : lane index 0..3
//   data         : lane data
//   rc4_wdata_o  : packed word
// ----------------------------------------------------------------------------
module rc4_core_decrypted_data
    import rc4_wctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      enable_write,
    input  logic [1:0]                writeLoc,
    input  logic [7:0]                data,
    output logic [WORD_BYTES*8-1:0]   rc4_wdata_o
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rc4_wdata_o <= '0;
        end else if (enable_write) begin
            rc4_wdata_o[{writeLoc, 3'b000} +: 8] <= data;
        end
    end

endmodule

// File: rtl/rc4_decrypt_write_ctrl.sv
// ----------------------------------------------------------------------------
// rc4_decrypt_write_ctrl
// Collects decrypted bytes, steers them into the external packer one lane at
// a time, pads a short final word with zeros, and issues one word write per
// packed word until the message length is exhausted.
//
// Ports:
//   clk, n_rst        : clock, synchronous active-low reset
//   start_i           : one-cycle message start (honoured only in IDLE)
//   base_addr_i       : first word address, sampled on start_i
//   byte_count_i      : message length in bytes, sampled on start_i
//   byte_valid_i/byte_i, byte_ready_o : byte stream (valid/ready)
//   enable_write_o, writeLoc_o, data_o : packer lane write port
//   mem_req_o, mem_addr_o, mem_ack_i   : word write (req/ack)
//   busy_o            : controller not in IDLE
//   done_o            : one-cycle message-complete pulse
//   state_o           : current FSM state, for observation
//
// Handshakes: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both 1. A word write is pending while mem_req_o is 1 and
// completes on the rising edge where mem_ack_i is also 1; mem_req_o and
// mem_addr_o do not change until then.
//
// Configuration macro: RC4_WCTRL_BIG_ENDIAN_EN (see rc4_wctrl_pkg).
// ----------------------------------------------------------------------------
module rc4_decrypt_write_ctrl
    import rc4_wctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  byte_count_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              enable_write_o,
    output logic [1:0]        writeLoc_o,
    output logic [7:0]        data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        state_o
);

    wctrl_state_t      state, state_n;
    logic [1:0]        lane, lane_n;
    logic [LEN_W-1:0]  count, count_n;
    logic [ADDR_W-1:0] addr, addr_n;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            lane  <= '0;
            count <= '0;
            addr  <= '0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            count <= count_n;
            addr  <= addr_n;
        end
    end

    always_comb begin
        state_n        = state;
        lane_n         = lane;
        count_n        = count;
        addr_n         = addr;
        byte_ready_o   = 1'b0;
        enable_write_o = 1'b0;
        writeLoc_o     = 2'd0;
        data_o         = 8'd0;
        mem_req_o      = 1'b0;
        done_o         = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    addr_n  = base_addr_i;
                    count_n = byte_count_i;
                    lane_n  = '0;
                    state_n = (byte_count_i == '0) ? DONE : COLLECT;
                end
            end

            COLLECT: begin
                byte_ready_o   = 1'b1;
                enable_write_o = byte_valid_i;
                data_o         = byte_i;
                writeLoc_o     = lane_map(lane);
                if (byte_valid_i) begin
                    lane_n  = lane + 2'd1;
                    count_n = count - LEN_W'(1);
                    // A full word (including a last byte on the final lane)
                    // goes straight to write; a short last word needs padding.
                    if (lane == LAST_LANE) begin
                        state_n = PACK_WAIT;
                    end else if (count == LEN_W'(1)) begin
                        state_n = FLUSH;
                    end
                end
            end

            FLUSH: begin
                enable_write_o = 1'b1;
                writeLoc_o     = lane_map(lane);
                lane_n         = lane + 2'd1;
                if (lane == LAST_LANE) begin
                    state_n = PACK_WAIT;
                end
            end

            // The packer registers the final lane on the edge that enters
            // this state; one idle cycle lets rc4_wdata_o settle before the
            // request goes out.
            PACK_WAIT: begin
                state_n = WRITE;
            end

            WRITE: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    addr_n  = addr + ADDR_W'(WORD_BYTES);
                    state_n = (count != '0) ? COLLECT : DONE;
                end
            end

            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign mem_addr_o = addr;
    assign busy_o     = (state != IDLE);
    assign state_o    = state;

endmodule

// File: tb/tb_rc4_decrypt_write_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rc4_decrypt_write_ctrl
// Controller paired with the packer. Expected word writes {addr, word} are
// queued when a message is issued; a monitor pops and compares on every
// completed write and watches request stability and output exclusivity.
// ----------------------------------------------------------------------------
module tb_rc4_decrypt_write_ctrl;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;
    localparam int W      = ADDR_W + 32;

`ifdef RC4_WCTRL_BIG_ENDIAN_EN
    localparam logic [31:0] W_DSIM = 32'h4453696D;
    localparam logic [31:0] W_CODE = 32'h636F6465;
    localparam logic [31:0] W_SIMO = 32'h53696D6F;
    localparam logic [31:0] W_N    = 32'h6E000000;
    localparam logic [31:0] W_WAIT = 32'h57616974;
    localparam logic [31:0] W_RC4  = 32'h52433421;
`else
    localparam logic [31:0] W_DSIM = 32'h6D695344;
    localparam logic [31:0] W_CODE = 32'h65646F63;
    localparam logic [31:0] W_SIMO = 32'h6F6D6953;
    localparam logic [31:0] W_N    = 32'h0000006E;
    localparam logic [31:0] W_WAIT = 32'h74696157;
    localparam logic [31:0] W_RC4  = 32'h21344352;
`endif

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [LEN_W-1:0]  byte_count_i;
    logic              byte_valid_i;
    logic [7:0]        byte_i;
    logic              byte_ready_o;
    logic              enable_write_o;
    logic [1:0]        writeLoc_o;
    logic [7:0]        data_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic              busy_o;
    logic              done_o;
    logic [2:0]        state_o;
    logic [31:0]       rc4_wdata;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // monitor counters, cleared by the main sequence per scenario
    int en_cnt, flush_cnt, req_cnt, done_cnt, wr_cnt, last_lat;
    int ack_delay = 0;

    rc4_decrypt_write_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .n_rst(n_rst), .start_i(start_i),
        .base_addr_i(base_addr_i), .byte_count_i(byte_count_i),
        .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
        .enable_write_o(enable_write_o), .writeLoc_o(writeLoc_o), .data_o(data_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
    );

    rc4_core_decrypted_data packer (
        .clk(clk), .n_rst(n_rst), .enable_write(enable_write_o),
        .writeLoc(writeLoc_o), .data(data_o), .rc4_wdata_o(rc4_wdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- memory ack responder ----------------
    initial begin
        int req_wait;
        req_wait  = 0;
        mem_ack_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_o && !mem_ack_i) begin
                if (req_wait >= ack_delay) begin
                    mem_ack_i = 1'b1;
                    req_wait  = 0;
                end else begin
                    req_wait++;
                end
            end else begin
                mem_ack_i = 1'b0;
                if (!mem_req_o) req_wait = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0]      exp;
        logic              prev_req, prev_ack;
        logic [ADDR_W-1:0] prev_addr;
        int cyc, word_start;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        cyc = 0; word_start = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (enable_write_o) en_cnt++;
            if (enable_write_o && !byte_ready_o) flush_cnt++;
            if (mem_req_o) req_cnt++;
            if (done_o) done_cnt++;
            if (!busy_o) word_start = -1;
            else if (byte_ready_o && byte_valid_i && word_start < 0) word_start = cyc;

            if (mem_req_o) begin
                checks++;
                if (byte_ready_o || enable_write_o) begin
                    errors++;
                    $display("FAIL req_exclusive: got ready=%0b en=%0b during request, required 0 0",
                             byte_ready_o, enable_write_o);
                end
                if (prev_req && !prev_ack) begin
                    checks++;
                    if (mem_addr_o !== prev_addr) begin
                        errors++;
                        $display("FAIL addr_stable: got %h, required %h", mem_addr_o, prev_addr);
                    end
                end
            end

            if (mem_req_o && mem_ack_i) begin
                wr_cnt++;
                last_lat   = cyc - word_start + 1;
                word_start = -1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                             mem_addr_o, rc4_wdata);
                end else begin
                    exp = exp_q.pop_front();
                    if ({mem_addr_o, rc4_wdata} !== exp) begin
                        errors++;
                        $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                                 mem_addr_o, rc4_wdata, exp[W-1:32], exp[31:0]);
                    end
                end
            end
            prev_req  = mem_req_o;
            prev_ack  = mem_ack_i;
            prev_addr = mem_addr_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic clear_counters();
        en_cnt = 0; flush_cnt = 0; req_cnt = 0; done_cnt = 0; wr_cnt = 0; last_lat = 0;
    endtask

    task automatic start_msg(input logic [ADDR_W-1:0] base, input int count);
        @(posedge clk);
        #1;
        start_i      = 1'b1;
        base_addr_i  = base;
        byte_count_i = LEN_W'(count);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard        = 0;
        byte_valid_i = 1'b1;
        byte_i       = b;
        @(negedge clk);
        while (!byte_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("byte_accept", 64'(byte_ready_o), 64'd1);
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!done_o && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", 64'(done_o), 64'd1);
        @(negedge clk);
        check("idle_after_done", {62'd0, busy_o, done_o}, 64'd0);
    endtask

    task automatic run_msg(input logic [ADDR_W-1:0] base, input string s);
        start_msg(base, s.len());
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        wait_done();
    endtask

    function automatic logic [63:0] all_outputs();
        return {14'd0, byte_ready_o, enable_write_o, writeLoc_o, data_o, mem_req_o,
                mem_addr_o, busy_o, done_o, state_o};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        n_rst = 1'b0; start_i = 1'b0; base_addr_i = '0; byte_count_i = '0;
        byte_valid_i = 1'b0; byte_i = '0;
        clear_counters();
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);

        // aligned message: two full words, 6-cycle word latency
        clear_counters();
        exp_q.push_back({32'h0000_0100, W_DSIM});
        exp_q.push_back({32'h0000_0104, W_CODE});
        run_msg(32'h0000_0100, "DSimcode");
        check("aligned_writes", 64'(wr_cnt), 64'd2);
        check("aligned_done_cnt", 64'(done_cnt), 64'd1);
        check("aligned_word_latency", 64'(last_lat), 64'd6);

        // partial word: last byte on lane 0, three pad cycles
        clear_counters();
        exp_q.push_back({32'h0000_2000, W_SIMO});
        exp_q.push_back({32'h0000_2004, W_N});
        run_msg(32'h0000_2000, "Simon");
        check("partial_writes", 64'(wr_cnt), 64'd2);
        check("partial_flush_cycles", 64'(flush_cnt), 64'd3);
        check("partial_done_cnt", 64'(done_cnt), 64'd1);

        // ack withheld for 7 cycles
        clear_counters();
        ack_delay = 7;
        exp_q.push_back({32'h0000_3000, W_WAIT});
        run_msg(32'h0000_3000, "Wait");
        ack_delay = 0;
        check("backpressure_writes", 64'(wr_cnt), 64'd1);
        check("backpressure_req_cycles", 64'(req_cnt), 64'd8);

        // zero length: DONE directly after the start edge
        clear_counters();
        start_msg(32'h0000_0500, 0);
        @(negedge clk);
        check("zero_done_pulse", {62'd0, busy_o, done_o}, 64'd3);
        @(negedge clk);
        check("zero_back_idle", {62'd0, busy_o, done_o}, 64'd0);
        repeat (3) @(negedge clk);
        check("zero_no_enable", 64'(en_cnt), 64'd0);
        check("zero_no_request", 64'(req_cnt), 64'd0);
        check("zero_done_cnt", 64'(done_cnt), 64'd1);

        // reset while a write request is pending
        clear_counters();
        ack_delay = 1000;
        start_msg(32'h0000_0100, 8);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h41 + i));
        guard = 0;
        @(negedge clk);
        while (!mem_req_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("midwrite_req_seen", 64'(mem_req_o), 64'd1);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        check("midwrite_reset_outputs", all_outputs(), 64'd0);
        check("midwrite_no_write", 64'(wr_cnt), 64'd0);

        // aligned message again after the reset
        clear_counters();
        exp_q.push_back({32'h0000_0100, W_DSIM});
        exp_q.push_back({32'h0000_0104, W_CODE});
        run_msg(32'h0000_0100, "DSimcode");
        check("rerun_writes", 64'(wr_cnt), 64'd2);
        check("rerun_done_cnt", 64'(done_cnt), 64'd1);

        // lane mapping word, with the address wrapping past the top
        clear_counters();
        exp_q.push_back({32'hFFFF_FFFC, W_RC4});
        exp_q.push_back({32'h0000_0000, W_RC4});
        run_msg(32'hFFFF_FFFC, "RC4!RC4!");
        check("wrap_writes", 64'(wr_cnt), 64'd2);

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
